// File: rtl/top.sv
// top: 5x5 weight-stationary systolic matmul C = A x B with internal global buffers.
// Define OUT_RELU_EN to zero negative result bytes before they are written to GBUFF_OUT.
module gbuff #(
  parameter int W  = 40,
  parameter int D  = 256,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] gbuff [0:D-1];
  always @(posedge clk) if (we_i) gbuff[waddr_i] <= wdata_i;
  assign rdata_o = gbuff[raddr_i];
endmodule

module top #(
  parameter int DATA_SIZE       = 8,
  parameter int ARRAY_SIZE      = 5,
  parameter int WORD_SIZE       = 40,
  parameter int GBUFF_ADDR_SIZE = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] m,
  input  logic [3:0] k,
  input  logic [3:0] n,
  output logic       done
);
  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_SIZE;
  localparam int AW = $clog2(GBUFF_ADDR_SIZE);
  localparam int TW = WORD_SIZE - 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d, m_q, k_q, n_q;
  logic [DW-1:0]        w_q [N][N];
  logic [DW-1:0]        a_q [N][N];
  logic [DW-1:0]        ps_q [N][N];
  logic [DW-1:0]        res_q [N][N];
  logic [DW-1:0]        a_in [N][N];
  logic [DW-1:0]        ps_in [N][N];
  logic [DW-1:0]        ps_d [N][N];
  logic [WORD_SIZE-1:0] sr_q [N];
  logic [WORD_SIZE-1:0] sr_d [N];
  logic [WORD_SIZE-1:0] a_rd, b_rd, a_msk, out_wd, out_unused;
  logic [N-1:0]         ld;
  logic [AW-1:0]        addr;

  function automatic logic [3:0] clamp(input logic [3:0] v);
    return (v == 4'd0 || v > 4'd5) ? 4'd5 : v;
  endfunction

  assign addr = AW'(cnt_q);
  assign done = state_q == DONE;

  gbuff #(.W(WORD_SIZE), .D(GBUFF_ADDR_SIZE)) GBUFF_A (
    .clk(clk), .we_i(1'b0), .waddr_i('0), .wdata_i('0), .raddr_i(addr), .rdata_o(a_rd));
  gbuff #(.W(WORD_SIZE), .D(GBUFF_ADDR_SIZE)) GBUFF_B (
    .clk(clk), .we_i(1'b0), .waddr_i('0), .wdata_i('0), .raddr_i(addr), .rdata_o(b_rd));
  gbuff #(.W(WORD_SIZE), .D(GBUFF_ADDR_SIZE)) GBUFF_OUT (
    .clk(clk), .we_i(state_q == WRITE), .waddr_i(addr), .wdata_i(out_wd), .raddr_i(addr),
    .rdata_o(out_unused));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = LOAD_W;
      end
      LOAD_W: if (cnt_q == k_q - 4'd1) begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED:  if (cnt_q == 4'd8) state_d = DRAIN;
      DRAIN: if (cnt_q == m_q + 4'd8) begin
        state_d = WRITE;
        cnt_d   = '0;
      end
      WRITE: if (cnt_q == m_q - 4'd1) state_d = DONE;
      DONE: begin
        cnt_d = '0;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row r loads GBUFF_A[r] at feed cycle r and shifts out one byte per cycle: the diagonal skew.
  always_comb begin
    for (int i = 0; i < N; i++)
      a_msk[TW-DW*i -: DW] = (4'(i) < m_q) ? a_rd[TW-DW*i -: DW] : '0;
    for (int r = 0; r < N; r++) begin
      ld[r]       = state_q == FEED && cnt_q == 4'(r) && 4'(r) < k_q;
      sr_d[r]     = ld[r] ? a_msk << DW : sr_q[r] << DW;
      a_in[r][0]  = ld[r] ? a_msk[TW -: DW] : sr_q[r][TW -: DW];
      ps_in[0][r] = '0;
      for (int c = 1; c < N; c++) begin
        a_in[r][c]  = a_q[r][c-1];
        ps_in[c][r] = ps_q[c-1][r];
      end
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ps_d[r][c] = ps_in[r][c] + DW'($signed(w_q[r][c]) * $signed(a_in[r][c]));
    for (int c = 0; c < N; c++)
`ifdef OUT_RELU_EN
      out_wd[TW-DW*c -: DW] = (4'(c) < n_q && !res_q[cnt_q[2:0]][c][DW-1]) ? res_q[cnt_q[2:0]][c] : '0;
`else
      out_wd[TW-DW*c -: DW] = (4'(c) < n_q) ? res_q[cnt_q[2:0]][c] : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      w_q     <= '{default: '0};
      a_q     <= '{default: '0};
      ps_q    <= '{default: '0};
      res_q   <= '{default: '0};
      sr_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start) begin
        m_q <= clamp(m);
        k_q <= clamp(k);
        n_q <= clamp(n);
      end
      for (int r = 0; r < N; r++) begin
        sr_q[r] <= state_q == IDLE ? '0 : sr_d[r];
        for (int c = 0; c < N; c++) begin
          w_q[r][c]  <= state_q == IDLE ? '0 :
                        (state_q == LOAD_W && cnt_q == 4'(r)) ? b_rd[TW-DW*c -: DW] : w_q[r][c];
          a_q[r][c]  <= state_q == IDLE ? '0 : a_in[r][c];
          ps_q[r][c] <= state_q == IDLE ? '0 : ps_d[r][c];
          // Deskew: C[r][c] is at the bottom of column c during cycle r+c+N.
          if ((state_q == FEED || state_q == DRAIN) && cnt_q == 4'(r + c + N) && 4'(r) < m_q)
            res_q[r][c] <= ps_q[N-1][c];
        end
      end
    end
endmodule

// File: tb/tb_top.sv
// tb_top: directed checks of the systolic matmul top, including OUT_RELU_EN expectations.
module tb_top;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] m = '0, k = '0, n = '0;
  logic       done;
  int         errors = 0, checks = 0;

  top dut (.clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n), .done(done));

  always #5 clk = ~clk;

  task automatic put(input int r, input logic [39:0] aw, input logic [39:0] bw);
    dut.GBUFF_A.gbuff[r] = aw;
    dut.GBUFF_B.gbuff[r] = bw;
  endtask

  task automatic put_binary();
    put(0, 40'h0001000001, 40'h0101010101);
    put(1, 40'h0100000100, 40'h0000010101);
    put(2, 40'h0000000101, 40'h0001000000);
    put(3, 40'h0000000101, 40'h0000010101);
    put(4, 40'h0001010001, 40'h0101000101);
  endtask

  // Starts a run, scrambles m/k/n after the sampling edge, waits (bounded) for done.
  task automatic run(input logic [3:0] mm, input logic [3:0] kk, input logic [3:0] nn, output int cyc);
    @(negedge clk);
    m = mm; k = kk; n = nn; start = 1'b1;
    @(posedge clk);
    #1 m = 4'd1; k = 4'd1; n = 4'd1;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic stop();
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done); end
  endtask

  task automatic test_binary();
    logic [39:0] ev [5];
    int cyc;
    ev = '{40'h0000010101, 40'h0202010202, 40'h0101000101, 40'h0001020202, 40'h0203020303};
    put_binary();
    run(4'd5, 4'd5, 4'd5, cyc);
    checks++;
    if (done !== 1'b1 || cyc > 40) begin errors++; $display("FAIL binary_latency done=%b cycles=%0d want done=1 cycles<=40", done, cyc); end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut.GBUFF_OUT.gbuff[r] !== ev[r]) begin errors++; $display("FAIL binary_out[%0d] got %h want %h", r, dut.GBUFF_OUT.gbuff[r], ev[r]); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", done); end
    stop();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_release got %b want 0", done); end
  endtask

  task automatic test_identity();
    logic [39:0] bv [5];
    int cyc;
    bv = '{40'h0102030405, 40'h0607080900, 40'h0A0B0C0D0E, 40'h0F10111213, 40'h1415161718};
    for (int r = 0; r < 5; r++) put(r, 40'h0100000000 >> (8 * r), bv[r]);
    run(4'd5, 4'd5, 4'd5, cyc);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL identity_done got %b want 1", done); end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut.GBUFF_OUT.gbuff[r] !== bv[r]) begin errors++; $display("FAIL identity_out[%0d] got %h want %h", r, dut.GBUFF_OUT.gbuff[r], bv[r]); end
    end
    stop();
  endtask

  task automatic test_partial();
    int cyc;
    for (int r = 0; r < 5; r++) put(r, 40'h0101010101, 40'h0101010101);
    run(4'd2, 4'd3, 4'd4, cyc);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL partial_done got %b want 1", done); end
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (dut.GBUFF_OUT.gbuff[r] !== 40'h0303030300) begin errors++; $display("FAIL partial_out[%0d] got %h want 0303030300", r, dut.GBUFF_OUT.gbuff[r]); end
    end
    checks++;
    if (dut.GBUFF_OUT.gbuff[2] !== 40'h0A0B0C0D0E) begin errors++; $display("FAIL partial_keep got %h want 0a0b0c0d0e", dut.GBUFF_OUT.gbuff[2]); end
    stop();
  endtask

  task automatic test_wrap();
    int cyc;
    for (int r = 0; r < 5; r++) put(r, 40'h7F7F7F7F7F, 40'h7F7F7F7F7F);
    run(4'd5, 4'd5, 4'd5, cyc);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut.GBUFF_OUT.gbuff[r] !== 40'h0505050505) begin errors++; $display("FAIL wrap_out[%0d] got %h want 0505050505", r, dut.GBUFF_OUT.gbuff[r]); end
    end
    stop();
  endtask

  task automatic test_negative();
    logic [39:0] ev;
    int cyc;
`ifdef OUT_RELU_EN
    ev = 40'h0000000000;
`else
    ev = 40'hFE00000000;
`endif
    put(0, 40'hFF00000000, 40'h0200000000);
    run(4'd1, 4'd1, 4'd1, cyc);
    checks++;
    if (dut.GBUFF_OUT.gbuff[0] !== ev) begin errors++; $display("FAIL neg_out got %h want %h", dut.GBUFF_OUT.gbuff[0], ev); end
    checks++;
    if (dut.GBUFF_OUT.gbuff[1] !== 40'h0505050505) begin errors++; $display("FAIL neg_keep got %h want 0505050505", dut.GBUFF_OUT.gbuff[1]); end
    stop();
  endtask

  task automatic test_clamp();
    logic [39:0] ev [5];
    int cyc;
    ev = '{40'h0000010101, 40'h0202010202, 40'h0101000101, 40'h0001020202, 40'h0203020303};
    put_binary();
    run(4'd0, 4'd9, 4'd15, cyc);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut.GBUFF_OUT.gbuff[r] !== ev[r]) begin errors++; $display("FAIL clamp_out[%0d] got %h want %h", r, dut.GBUFF_OUT.gbuff[r], ev[r]); end
    end
    stop();
  endtask

  task automatic test_rst_midrun();
    logic [39:0] ev [5];
    logic        seen;
    int cyc;
    ev = '{40'h0000010101, 40'h0202010202, 40'h0101000101, 40'h0001020202, 40'h0203020303};
    for (int r = 0; r < 5; r++) put(r, 40'h0101010101, 40'h0101010101);
    @(negedge clk);
    m = 4'd5; k = 4'd5; n = 4'd5; start = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_feed_done got %b want 0", done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | done;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_abort done_seen=%b want 0", seen); end
    put_binary();
    run(4'd5, 4'd5, 4'd5, cyc);
    checks++;
    if (done !== 1'b1 || cyc > 40) begin errors++; $display("FAIL rst_rerun done=%b cycles=%0d want done=1 cycles<=40", done, cyc); end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut.GBUFF_OUT.gbuff[r] !== ev[r]) begin errors++; $display("FAIL rst_out[%0d] got %h want %h", r, dut.GBUFF_OUT.gbuff[r], ev[r]); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_async got %b want 0", done); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_binary();
    test_identity();
    test_partial();
    test_wrap();
    test_negative();
    test_clamp();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
